// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall/flush and forwarding control for the 5-stage core.
// Optional EX-stage forwarding is enabled by defining HAZ_FORWARDING_EN.
module pipe_hazard_ctrl #(
  parameter int HAZ_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          id_instr,
  input  logic                 id_valid,
  input  logic                 ex_redirect,
  output logic                 pc_write_en,
  output logic                 if_id_write_en,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic                 jal_redirect,
  output logic [1:0]           forward_a,
  output logic [1:0]           forward_b,
  output logic [HAZ_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } shd_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } shd_ex_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [6:0] opc;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       use1, use2, wr_op, is_ld, is_jal;
  logic       id_wr;
  logic       hit1_ex, hit2_ex, hit1_mem, hit2_mem;
  logic       stall;

  shd_ex_t ex_q, ex_d;
  shd_t    mem_q, wb_q;
  logic [HAZ_CNT_W-1:0] cnt_q, cnt_d;

  assign opc    = id_instr[6:0];
  assign id_rd  = id_instr[11:7];
  assign id_rs1 = id_instr[19:15];
  assign id_rs2 = id_instr[24:20];

  // Opcode decode: which sources are read, whether rd is written.
  always_comb begin
    use1   = 1'b0;
    use2   = 1'b0;
    wr_op  = 1'b0;
    is_ld  = 1'b0;
    is_jal = 1'b0;
    unique case (opc)
      OP_R:     begin use1 = 1'b1; use2 = 1'b1; wr_op = 1'b1; end
      OP_IALU:  begin use1 = 1'b1; wr_op = 1'b1; end
      OP_LOAD:  begin use1 = 1'b1; wr_op = 1'b1; is_ld = 1'b1; end
      OP_STORE: begin use1 = 1'b1; use2 = 1'b1; end
      OP_BR:    begin use1 = 1'b1; use2 = 1'b1; end
      OP_JALR:  begin use1 = 1'b1; wr_op = 1'b1; end
      OP_JAL:   begin wr_op = 1'b1; is_jal = 1'b1; end
      OP_LUI:   wr_op = 1'b1;
      OP_AUIPC: wr_op = 1'b1;
      default:  ;
    endcase
  end

  assign id_wr = wr_op && (id_rd != 5'd0);

  assign hit1_ex  = use1 && (id_rs1 != 5'd0) && ex_q.v && ex_q.wr
                    && (ex_q.rd == id_rs1);
  assign hit2_ex  = use2 && (id_rs2 != 5'd0) && ex_q.v && ex_q.wr
                    && (ex_q.rd == id_rs2);
  assign hit1_mem = use1 && (id_rs1 != 5'd0) && mem_q.v && mem_q.wr
                    && (mem_q.rd == id_rs1);
  assign hit2_mem = use2 && (id_rs2 != 5'd0) && mem_q.v && mem_q.wr
                    && (mem_q.rd == id_rs2);

`ifdef HAZ_FORWARDING_EN
  logic f1_mem, f1_wb, f2_mem, f2_wb;

  // Load-use is the only hazard forwarding cannot cover.
  always_comb begin
    stall = id_valid && !ex_redirect && ex_q.ld
            && (hit1_ex || hit2_ex);
  end

  assign f1_mem = ex_q.v && ex_q.u1 && (ex_q.rs1 != 5'd0)
                  && mem_q.v && mem_q.wr && (mem_q.rd == ex_q.rs1);
  assign f1_wb  = ex_q.v && ex_q.u1 && (ex_q.rs1 != 5'd0)
                  && wb_q.v && wb_q.wr && (wb_q.rd == ex_q.rs1);
  assign f2_mem = ex_q.v && ex_q.u2 && (ex_q.rs2 != 5'd0)
                  && mem_q.v && mem_q.wr && (mem_q.rd == ex_q.rs2);
  assign f2_wb  = ex_q.v && ex_q.u2 && (ex_q.rs2 != 5'd0)
                  && wb_q.v && wb_q.wr && (wb_q.rd == ex_q.rs2);

  // MEM result is younger than WB, so it wins.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (f1_mem)     forward_a = 2'b10;
    else if (f1_wb) forward_a = 2'b01;
    if (f2_mem)     forward_b = 2'b10;
    else if (f2_wb) forward_b = 2'b01;
  end
`else
  // Without bypass paths, wait until the producer has reached WB.
  always_comb begin
    stall = id_valid && !ex_redirect
            && (hit1_ex || hit2_ex || hit1_mem || hit2_mem);
  end

  assign forward_a = 2'b00;
  assign forward_b = 2'b00;
`endif

  logic unused_sink;
  assign unused_sink = ^{id_instr[31:25], id_instr[14:12],
                         ex_q, mem_q, wb_q, hit1_mem, hit2_mem};

  assign pc_write_en    = !stall;
  assign if_id_write_en = !stall;
  assign id_ex_bubble   = stall || ex_redirect;
  assign jal_redirect   = id_valid && is_jal && !stall && !ex_redirect;
  assign if_id_flush    = ex_redirect || jal_redirect;
  assign stall_count    = cnt_q;

  // Next EX shadow: the ID instruction unless it is held or squashed.
  always_comb begin
    ex_d     = '0;
    ex_d.v   = id_valid && !stall && !ex_redirect;
    ex_d.rd  = id_rd;
    ex_d.wr  = id_wr;
    ex_d.ld  = is_ld;
    ex_d.rs1 = id_rs1;
    ex_d.rs2 = id_rs2;
    ex_d.u1  = use1;
    ex_d.u2  = use2;
    if (!ex_d.v) ex_d = '0;
  end

  // Saturating stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Shadow pipeline advance and counter update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= '{v: ex_q.v, rd: ex_q.rd, wr: ex_q.wr, ld: ex_q.ld};
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
